// File: rtl/r_trace_pkg.sv
// Shared constants and entry packing for the R-type result tracer.
package r_trace_pkg;

  // Entry field layout: {seq, of, zf, F}
  localparam int F_LSB   = 0;
  localparam int ZF_BIT  = 32;
  localparam int OF_BIT  = 33;
  localparam int SEQ_LSB = 34;

  // Default configuration
  localparam int DEF_DEPTH  = 8;
  localparam int DEF_SEQ_W  = 8;
  localparam int DEF_DROP_W = 16;

  // Widest sequence number the packing helper supports
  localparam int MAX_SEQ_W = 32;

  // Build a full-width entry; callers truncate to SEQ_W+34 bits.
  function automatic logic [MAX_SEQ_W+33:0] pack_entry(
    input logic [MAX_SEQ_W-1:0] seq,
    input logic                 of_b,
    input logic                 zf_b,
    input logic [31:0]          f
  );
    logic [MAX_SEQ_W+33:0] e;
    e                       = '0;
    e[F_LSB +: 32]          = f;
    e[ZF_BIT]               = zf_b;
    e[OF_BIT]               = of_b;
    e[SEQ_LSB +: MAX_SEQ_W] = seq;
    return e;
  endfunction

endpackage

// File: rtl/r_trace_fifo.sv
// First-word-fall-through FIFO with flop storage and registered head/valid.
// The head register is loaded with the entry that will be at the front
// after each edge, so a push into an empty FIFO is visible one cycle later.
module r_trace_fifo #(
  parameter  int W     = 42,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en_i,
  input  logic [W-1:0]  wr_data_i,
  output logic          full_o,
  input  logic          rd_en_i,
  output logic [W-1:0]  rd_data_o,
  output logic          empty_o,
  output logic [LW-1:0] level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LW-1:0] level_q, level_d;
  logic [W-1:0]  head_q, head_d;
  logic          valid_q, valid_d;
  logic          full_s;
  logic          rd_ok_s;
  logic          wr_ok_s;

  assign full_s  = (level_q == LW'(DEPTH));
  // A read is only honoured when something is there; no underflow.
  assign rd_ok_s = rd_en_i & valid_q;
  // When full, a write only fits if the head leaves in the same cycle.
  assign wr_ok_s = wr_en_i & (~full_s | rd_ok_s);

  // Next pointers, occupancy and the entry that becomes the head.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    head_d   = '0;
    if (wr_ok_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (rd_ok_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({wr_ok_s, rd_ok_s})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    // The slot being written becomes the head only when it is the next
    // read location (empty FIFO, or the last entry is popped).
    if (wr_ok_s && (wr_ptr_q == rd_ptr_d)) begin
      head_d = wr_data_i;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end
    valid_d = (level_d != '0);
  end

  // Storage array; cleared on reset so the head reads zero afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_ok_s) begin
      mem_q[wr_ptr_q] <= wr_data_i;
    end
  end

  // Pointers, level and registered head/valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
    end
  end

  assign full_o    = full_s;
  assign empty_o   = ~valid_q;
  assign rd_data_o = head_q;
  assign level_o   = level_q;

endmodule

// File: rtl/r_result_tracer.sv
// Result tracer: tags each retired R-type result with a sequence number,
// buffers it, and drains it over valid/ready. Never back-pressures the
// core; entries arriving while full are dropped and counted.
module r_result_tracer
  import r_trace_pkg::*;
#(
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int SEQ_W  = DEF_SEQ_W,
  parameter  int DROP_W = DEF_DROP_W,
  localparam int LW     = $clog2(DEPTH) + 1,
  localparam int EW     = SEQ_W + 34
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_en,
  input  logic              res_valid,
  input  logic [31:0]       res_F,
  input  logic              res_zf,
  input  logic              res_of,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW-1:0]     out_data,
  output logic [LW-1:0]     level,
  output logic [DROP_W-1:0] drop_cnt,
  output logic              of_seen
);

  logic [SEQ_W-1:0]  seq_q, seq_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              of_seen_q, of_seen_d;
  logic              push_att_s;
  logic              pop_s;
  logic              drop_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [EW-1:0]     entry_s;
  logic [EW-1:0]     head_s;
  logic [LW-1:0]     level_s;

  assign push_att_s = cap_en & res_valid;
  assign pop_s      = out_ready & ~fifo_empty_s;
  // Full with a simultaneous pop still accepts, so only this case drops.
  assign drop_s     = push_att_s & fifo_full_s & ~pop_s;
  assign entry_s    = EW'(pack_entry(MAX_SEQ_W'(seq_q), res_of, res_zf, res_F));

  r_trace_fifo #(
    .W     (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst),
    .wr_en_i   (push_att_s),
    .wr_data_i (entry_s),
    .full_o    (fifo_full_s),
    .rd_en_i   (pop_s),
    .rd_data_o (head_s),
    .empty_o   (fifo_empty_s),
    .level_o   (level_s)
  );

  // Sequence, saturating drop count and sticky overflow next-state.
  always_comb begin
    seq_d     = seq_q;
    drop_d    = drop_q;
    of_seen_d = of_seen_q;
    // seq advances on every attempt so gaps reveal drops.
    if (push_att_s) begin
      seq_d = seq_q + SEQ_W'(1);
    end else begin
      seq_d = seq_q;
    end
    if (drop_s && (drop_q != {DROP_W{1'b1}})) begin
      drop_d = drop_q + DROP_W'(1);
    end else begin
      drop_d = drop_q;
    end
    if (push_att_s && res_of) begin
      of_seen_d = 1'b1;
    end else begin
      of_seen_d = of_seen_q;
    end
  end

  // Tracer bookkeeping registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q     <= '0;
      drop_q    <= '0;
      of_seen_q <= 1'b0;
    end else begin
      seq_q     <= seq_d;
      drop_q    <= drop_d;
      of_seen_q <= of_seen_d;
    end
  end

  assign out_valid = ~fifo_empty_s;
  assign out_data  = head_s;
  assign level     = level_s;
  assign drop_cnt  = drop_q;
  assign of_seen   = of_seen_q;

endmodule
